soc2_req_arbiter: RTL and testbench



---
 rtl/soc2_req_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_soc2_req_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc2_req_arbiter.sv
// Round-robin arbiter for NUM_REQ asynchronous request lines sharing one
// downstream resource. Requests are synchronised, one grant is held at a
// time, and a hold timeout plus an Avalon-MM register block let software
// mask requesters, force a release and service interrupts.
//
// Avalon-MM handshake: write and read are single-cycle strobes with no
// waitrequest; a write takes effect at the edge where it is sampled, and
// readdata is loaded at the edge where read is sampled (latency 1) and
// holds its value otherwise.
module soc2_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               write,
    input  logic [31:0]        writedata,
    input  logic               read,
    output logic [31:0]        readdata,
    input  logic [NUM_REQ-1:0] req_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic               irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] NREQ4 = 4'(NUM_REQ);

    state_t                 state;
    logic [NUM_REQ-1:0]     req_m;
    logic [NUM_REQ-1:0]     req_s;
    logic [NUM_REQ-1:0]     mask;
    logic [TIMEOUT_W-1:0]   timeout;
    logic [1:0]             irq_en;
    logic [1:0]             irq_status;
    logic [2:0]             ptr;
    logic [TIMEOUT_W-1:0]   hold;

    // 8-bit views so a 3-bit index always matches the vector width
    logic [7:0]             elig8;
    logic [7:0]             req8;
    logic [7:0]             mask8;
    logic [7:0]             grant8;
    logic [7:0]             sel_onehot;

    logic                   sel_found;
    logic [2:0]             sel_idx;
    logic [3:0]             sum;
    logic [2:0]             cand;

    logic [TIMEOUT_W:0]     hold_inc;
    logic                   timeout_hit;
    logic                   rel_write;
    logic                   grant_drop;
    logic                   set_grant;
    logic                   set_timeout;
    logic [1:0]             irq_clr;
    logic                   unused_bits;

    assign elig8      = 8'(req_s & mask);
    assign req8       = 8'(req_s);
    assign mask8      = 8'(mask);
    assign grant8     = 8'(grant_out);
    assign sel_onehot = 8'd1 << sel_idx;

    assign hold_inc    = {1'b0, hold} + {{TIMEOUT_W{1'b0}}, 1'b1};
    assign timeout_hit = (timeout != '0) && (hold_inc == {1'b0, timeout});
    assign rel_write   = write && (address == 3'd2);
    // ptr holds the granted index while in GRANT
    assign grant_drop  = !req8[ptr] || !mask8[ptr] || rel_write || timeout_hit;
    assign set_grant   = (state == IDLE) && (elig8 != 8'd0);
    assign set_timeout = (state == GRANT) && timeout_hit;
    assign irq_clr     = (write && (address == 3'd5)) ? writedata[1:0] : 2'b00;
    assign unused_bits = ^{writedata, sel_onehot};

    // Round-robin pick: first eligible index after ptr, wrapping at NUM_REQ
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 3'd0;
        sum       = 4'd0;
        cand      = 3'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            if (sum >= NREQ4) begin
                sum = sum - NREQ4;
            end
            cand = sum[2:0];
            if (!sel_found && elig8[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous request lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_m <= '0;
            req_s <= '0;
        end else begin
            req_m <= req_in;
            req_s <= req_m;
        end
    end

    // Arbitration FSM: IDLE picks, GRANT holds until a release cause, GAP idles one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_out <= '0;
            ptr       <= 3'(NUM_REQ - 1);
            hold      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_out <= sel_onehot[NUM_REQ-1:0];
                        ptr       <= sel_idx;
                        hold      <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_drop) begin
                        grant_out <= '0;
                        state     <= GAP;
                    end else if (hold != '1) begin
                        hold <= hold_inc[TIMEOUT_W-1:0];
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    grant_out <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Software registers and interrupt; a same-cycle set beats a RW1C clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask       <= '0;
            timeout    <= '0;
            irq_en     <= 2'b00;
            irq_status <= 2'b00;
            irq        <= 1'b0;
        end else begin
            if (write && (address == 3'd1)) mask    <= writedata[NUM_REQ-1:0];
            if (write && (address == 3'd3)) timeout <= writedata[TIMEOUT_W-1:0];
            if (write && (address == 3'd4)) irq_en  <= writedata[1:0];
            irq_status <= (irq_status & ~irq_clr) | {set_timeout, set_grant};
            irq        <= |(irq_status & irq_en);
        end
    end

    // Registered read port, loaded only when read is sampled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            case (address)
                3'd0:    readdata <= {12'd0, ptr, (state == GRANT), grant8, req8};
                3'd1:    readdata <= 32'(mask);
                3'd3:    readdata <= 32'(timeout);
                3'd4:    readdata <= {30'd0, irq_en};
                3'd5:    readdata <= {30'd0, irq_status};
                default: readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_soc2_req_arbiter.sv
// Bench for soc2_req_arbiter: directed scenarios with hand-computed values,
// then randomized traffic, with every cycle compared to a behavioural model.
module tb_soc2_req_arbiter;

    localparam int N    = 4;
    localparam int TW   = 16;
    localparam int HMAX = (1 << TW) - 1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    address = '0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic          read = 1'b0;
    logic [31:0]   readdata;
    logic [N-1:0]  req_in = '0;
    logic [N-1:0]  grant_out;
    logic          irq;

    always #5 clk = ~clk;

    soc2_req_arbiter #(.NUM_REQ(N), .TIMEOUT_W(TW)) dut (
        .clk       (clk),
        .reset     (rst),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .read      (read),
        .readdata  (readdata),
        .req_in    (req_in),
        .grant_out (grant_out),
        .irq       (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // granted index (-1 when none), a pending one-cycle gap, and a queue of
    // raw request samples standing in for the two-stage synchroniser.
    logic [N-1:0]  sync_q[$];
    logic [N-1:0]  m_mask;
    logic [15:0]   m_timeout;
    logic [1:0]    m_en;
    logic [1:0]    m_st;
    logic          m_irq;
    logic [31:0]   m_rd;
    int            m_ptr;
    int            m_gidx;
    int            m_hold;
    bit            m_gap;

    function automatic logic [N-1:0] m_req_s();
        return sync_q[0];
    endfunction

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] g = '0;
        if (m_gidx >= 0) g[m_gidx] = 1'b1;
        return g;
    endfunction

    function automatic logic [31:0] m_reg(input logic [2:0] a);
        logic [31:0] v = '0;
        case (a)
            3'd0: begin
                v[7:0]   = 8'(m_req_s());
                v[15:8]  = 8'(m_grant());
                v[16]    = (m_gidx >= 0);
                v[19:17] = 3'(m_ptr);
            end
            3'd1: v = 32'(m_mask);
            3'd3: v = 32'(m_timeout);
            3'd4: v = 32'(m_en);
            3'd5: v = 32'(m_st);
            default: v = '0;
        endcase
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    = '{'0, '0};
            m_mask    = '0;
            m_timeout = '0;
            m_en      = '0;
            m_st      = '0;
            m_irq     = 1'b0;
            m_rd      = '0;
            m_ptr     = N - 1;
            m_gidx    = -1;
            m_hold    = 0;
            m_gap     = 1'b0;
        end else begin
            logic [N-1:0] elig;
            logic [31:0]  n_rd;
            int           n_ptr, n_gidx, n_hold, idx;
            bit           n_gap, to, s0, s1;
            elig   = m_req_s() & m_mask;
            n_rd   = read ? m_reg(address) : m_rd;
            n_ptr  = m_ptr;
            n_gidx = m_gidx;
            n_hold = m_hold;
            n_gap  = m_gap;
            s0     = 1'b0;
            s1     = 1'b0;
            if (m_gidx < 0 && !m_gap) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (n_gidx < 0 && elig[idx]) begin
                        n_gidx = idx;
                        n_ptr  = idx;
                        n_hold = 0;
                        s0     = 1'b1;
                    end
                end
            end else if (m_gidx >= 0) begin
                to = (m_timeout != 0) && (m_hold + 1 == int'(m_timeout));
                s1 = to;
                if (!m_req_s()[m_gidx] || !m_mask[m_gidx] || (write && address == 3'd2) || to) begin
                    n_gidx = -1;
                    n_gap  = 1'b1;
                end else if (m_hold < HMAX) begin
                    n_hold = m_hold + 1;
                end
            end else begin
                n_gap = 1'b0;
            end
            m_irq = |(m_st & m_en);
            if (write) begin
                case (address)
                    3'd1: m_mask    = writedata[N-1:0];
                    3'd3: m_timeout = writedata[15:0];
                    3'd4: m_en      = writedata[1:0];
                    3'd5: m_st      = m_st & ~writedata[1:0];
                    default: ;
                endcase
            end
            m_st   = m_st | {s1, s0};
            m_rd   = n_rd;
            m_ptr  = n_ptr;
            m_gidx = n_gidx;
            m_hold = n_hold;
            m_gap  = n_gap;
            void'(sync_q.pop_front());
            sync_q.push_back(req_in);
        end
    end

    // ---------------- scoreboard compare, every cycle out of reset ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("grant_out", 32'(grant_out), 32'(m_grant()));
            chk("irq", 32'(irq), 32'(m_irq));
            chk("readdata", readdata, m_rd);
            chk("grant_onehot0", 32'($onehot0(grant_out)), 32'd1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        req_in = '0;
        write  = 1'b0;
        read   = 1'b0;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d    = readdata;
    endtask

    // Waits at negedges for a nonzero grant, bounded by budget cycles
    task automatic wait_grant(input string name, output logic [N-1:0] g);
        g = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant_out != '0) begin
                g = grant_out;
                break;
            end
        end
        if (g == '0) chk({name, "_wait_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0]  rd;
        logic [N-1:0] g;
        int           cnt;

        do_reset();
        chk("reset_grant", 32'(grant_out), 32'd0);
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);

        // 1: basic grant latency and drop
        bus_write(3'd1, 32'hF);
        req_in = 4'b0001;
        repeat (2) @(posedge clk);
        #1 chk("t1_no_grant_before_edge3", 32'(grant_out), 32'd0);
        @(posedge clk);
        #1 chk("t1_grant_edge3", 32'(grant_out), 32'h1);
        bus_read(3'd5, rd);
        chk("t1_irq_status", rd, 32'h1);
        req_in = '0;
        repeat (3) @(posedge clk);
        #1 chk("t1_grant_dropped", 32'(grant_out), 32'd0);
        @(posedge clk);
        #1 chk("t1_gap_zero", 32'(grant_out), 32'd0);

        // 2: fairness with forced releases
        do_reset();
        bus_write(3'd1, 32'hF);
        req_in = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant("t2", g);
            chk("t2_order", 32'(onehot_idx(g)), 32'(k % N));
            bus_write(3'd2, 32'h0);
        end
        req_in = '0;

        // 3: hold timeout and interrupt
        do_reset();
        bus_write(3'd1, 32'hF);
        bus_write(3'd3, 32'd5);
        bus_write(3'd4, 32'h2);
        req_in = 4'b0100;
        wait_grant("t3", g);
        chk("t3_grant", 32'(g), 32'h4);
        cnt = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (grant_out != 4'b0100) break;
            cnt++;
        end
        chk("t3_hold_cycles", 32'(cnt), 32'd5);
        req_in = '0;
        @(negedge clk);
        chk("t3_irq_set", 32'(irq), 32'd1);
        bus_read(3'd5, rd);
        chk("t3_irq_status", rd, 32'h3);
        bus_write(3'd5, 32'h2);
        @(negedge clk);
        chk("t3_irq_cleared", 32'(irq), 32'd0);
        bus_read(3'd0, rd);
        chk("t3_ptr", 32'(rd[19:17]), 32'd2);

        // 4: masking
        do_reset();
        bus_write(3'd1, 32'h2);
        req_in = 4'b0011;
        wait_grant("t4", g);
        chk("t4_masked_grant", 32'(g), 32'h2);
        bus_write(3'd1, 32'h0);
        repeat (2) @(negedge clk);
        chk("t4_released", 32'(grant_out), 32'd0);
        bus_read(3'd0, rd);
        chk("t4_busy", 32'(rd[16]), 32'd0);
        req_in = '0;

        // 5: asynchronous reset mid-grant
        do_reset();
        bus_write(3'd1, 32'hF);
        bus_write(3'd3, 32'd100);
        req_in = 4'b1000;
        wait_grant("t5", g);
        bus_read(3'd0, rd);
        chk("t5_status_granted", rd, 32'h0007_0808);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_grant", 32'(grant_out), 32'd0);
        chk("t5_async_readdata", readdata, 32'd0);
        req_in = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus_read(3'd1, rd);
        chk("t5_mask_reset", rd, 32'd0);
        bus_read(3'd3, rd);
        chk("t5_timeout_reset", rd, 32'd0);
        bus_read(3'd4, rd);
        chk("t5_irq_en_reset", rd, 32'd0);
        bus_read(3'd5, rd);
        chk("t5_irq_status_reset", rd, 32'd0);
        bus_read(3'd0, rd);
        chk("t5_status_reset", rd, 32'h0006_0000);

        // 6: register readback
        bus_write(3'd3, 32'h1234);
        bus_read(3'd3, rd);
        chk("t6_timeout_rb", rd, 32'h0000_1234);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd2, rd);
        chk("t6_addr2", rd, 32'd0);
        bus_read(3'd6, rd);
        chk("t6_addr6", rd, 32'd0);
        bus_read(3'd7, rd);
        chk("t6_addr7", rd, 32'd0);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) req_in = N'($urandom);
            write = 1'b0;
            read  = 1'b0;
            case ($urandom_range(0, 5))
                0: begin
                    write     = 1'b1;
                    address   = 3'($urandom_range(0, 7));
                    writedata = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 12));
                end
                1, 2: begin
                    read    = 1'b1;
                    address = 3'($urandom_range(0, 7));
                end
                default: ;
            endcase
        end
        @(negedge clk);
        write = 1'b0;
        read  = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
